// File: rtl/u712_pkg.sv
// u712_pkg: shared CPU size codes and bus sizer state encoding
package u712_pkg;
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;
    typedef enum logic [1:0] {IDLE, UPPER, LOWER, DONE} sizer_state_t;
endpackage

// File: rtl/u712_bus_sizer_if.sv
// u712_bus_sizer_if: CPU transfer and Agnus word-cycle signals of the bus sizer
interface u712_bus_sizer_if;
    logic        TSn;
    logic        CYCLE_HIT;
    logic        RnW;
    logic [1:0]  A;
    logic [1:0]  SIZ;
    logic [31:0] CPU_DIN;
    logic [31:0] CPU_DOUT;
    logic        CPU_DOUT_EN;
    logic        WORD_REQ;
    logic        WORD_A1;
    logic        WORD_RNW;
    logic        UDS;
    logic        LDS;
    logic [15:0] WORD_WR_DATA;
    logic [15:0] WORD_RD_DATA;
    logic        WORD_ACK;
    logic        SIZER_TACK;
    logic        TIMEOUT;
    logic        BUSY;
    modport slave (
        input  TSn, CYCLE_HIT, RnW, A, SIZ, CPU_DIN, WORD_RD_DATA, WORD_ACK,
        output CPU_DOUT, CPU_DOUT_EN, WORD_REQ, WORD_A1, WORD_RNW, UDS, LDS,
               WORD_WR_DATA, SIZER_TACK, TIMEOUT, BUSY
    );
    modport master (
        output TSn, CYCLE_HIT, RnW, A, SIZ, CPU_DIN, WORD_RD_DATA, WORD_ACK,
        input  CPU_DOUT, CPU_DOUT_EN, WORD_REQ, WORD_A1, WORD_RNW, UDS, LDS,
               WORD_WR_DATA, SIZER_TACK, TIMEOUT, BUSY
    );
endinterface

// File: rtl/u712_byte_lane_decode.sv
// u712_byte_lane_decode: CPU A[1:0]/SIZ to byte enables, BE[3] = D31:24
module u712_byte_lane_decode
    import u712_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] siz,
    output logic [3:0] be
);
    // misaligned words are truncated at the long-word boundary
    assign be = (siz == SIZ_LONG || siz == SIZ_LINE) ? 4'b1111 :
                (siz == SIZ_WORD) ? 4'b1100 >> a : 4'b1000 >> a;
endmodule

// File: rtl/u712_bus_sizer.sv
// u712_bus_sizer: splits one 68040 transfer into one or two Agnus 16-bit word cycles,
// assembles read data and issues a single termination pulse
module u712_bus_sizer
    import u712_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023,
    parameter int TO_W        = 10
) (
    input logic             CLK40,
    input logic             RESET,
    u712_bus_sizer_if.slave bus
);
    sizer_state_t    state, state_nx;
    logic [3:0]      be, be_q;
    logic            rnw_q, to_q, accept, in_word, timed_out;
    logic [31:0]     din_q, dout;
    logic [TO_W-1:0] cnt;

    u712_byte_lane_decode u_decode (.a(bus.A), .siz(bus.SIZ), .be(be));

    assign accept    = state == IDLE && !bus.TSn && bus.CYCLE_HIT;
    assign in_word   = state == UPPER || state == LOWER;
    // an ACK arriving on the expiry edge still completes the word normally
    assign timed_out = in_word && !bus.WORD_ACK && cnt == TO_W'(ACK_TIMEOUT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (be[3] | be[2]) ? UPPER : LOWER;
            UPPER:   if (bus.WORD_ACK) state_nx = (be_q[1] | be_q[0]) ? LOWER : DONE;
                     else if (timed_out) state_nx = DONE;
            LOWER:   if (bus.WORD_ACK || timed_out) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state <= IDLE;
            be_q  <= '0;
            rnw_q <= 1'b0;
            din_q <= '0;
            dout  <= '0;
            cnt   <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (in_word && state_nx == state) ? cnt + TO_W'(1) : '0;
            to_q  <= timed_out;
            if (accept) begin
                be_q  <= be;
                rnw_q <= bus.RnW;
                din_q <= bus.CPU_DIN;
            end
            // a forced termination fills every half that never got its ACK
            if (rnw_q && state == UPPER && (bus.WORD_ACK || timed_out))
                dout[31:16] <= bus.WORD_ACK ? bus.WORD_RD_DATA : 16'hFFFF;
            if (rnw_q && (timed_out ? (be_q[1] | be_q[0]) : state == LOWER && bus.WORD_ACK))
                dout[15:0] <= timed_out ? 16'hFFFF : bus.WORD_RD_DATA;
        end
    end

    assign bus.BUSY         = state != IDLE;
    assign bus.WORD_REQ     = in_word;
    assign bus.WORD_A1      = state == LOWER;
    assign bus.WORD_RNW     = in_word && rnw_q;
    assign bus.UDS          = state == UPPER ? be_q[3] : state == LOWER ? be_q[1] : 1'b0;
    assign bus.LDS          = state == UPPER ? be_q[2] : state == LOWER ? be_q[0] : 1'b0;
    assign bus.WORD_WR_DATA = state == UPPER ? din_q[31:16] : state == LOWER ? din_q[15:0] : 16'h0;
    assign bus.SIZER_TACK   = state == DONE;
    assign bus.TIMEOUT      = state == DONE && to_q;
    assign bus.CPU_DOUT_EN  = state == DONE && rnw_q;
    assign bus.CPU_DOUT     = dout;
endmodule
